// File: rtl/parammod_arb_pkg.sv
// parammod_arb_pkg: shared state type and pointer/mask helpers for the round-robin arbiter
package parammod_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

    // one bit of the thermometer mask that keeps positions at or above the pointer
    function automatic logic ge_bit(input int unsigned i, input int unsigned p);
        return i >= p;
    endfunction

endpackage

// File: rtl/pri_enc.sv
// pri_enc: lowest-index priority encoder with one-hot and binary outputs
module pri_enc #(
    parameter int    W   = 8,
    parameter string ACT = "HIGH",
    localparam int   IW  = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [W-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [W-1:0] v;

    assign v     = (ACT == "LOW") ? ~vec : vec;
    assign valid = |v;

    // scanning downward leaves the lowest set bit as the final winner
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter with hold-until-done grants
// Define RR_ARB_TIMEOUT_EN to force a release after MAX_HOLD cycles of ownership.
module rr_arbiter
    import parammod_arb_pkg::*;
#(
    parameter int  REQ      = 8,
    parameter int  MAX_HOLD = 16,
    localparam int ID       = $clog2(REQ)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [REQ-1:0] req,
    input  logic           done,
    output logic [REQ-1:0] grant,
    output logic           grant_valid,
    output logic [ID-1:0]  grant_id,
    output logic           timeout
);

    arb_state_t     state, state_n;
    logic [ID-1:0]  ptr, ptr_n, arb_ptr, id_n, m_idx, u_idx, win_idx;
    logic [REQ-1:0] grant_n, arb_req, mask, m_onehot, u_onehot, win;
    logic           m_valid, u_valid, release_c, expired, forced, to_n;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;
    assign expired = (state == BUSY) && (hold_cnt == HW'(MAX_HOLD - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_cnt <= '0;
        else       hold_cnt <= (state == IDLE || release_c) ? '0 : hold_cnt + HW'(1);
    end
`else
    assign expired = 1'b0;
`endif

    assign release_c   = (state == BUSY) && (done || !req[grant_id] || expired);
    assign forced      = expired && !done && req[grant_id];
    assign grant_valid = |grant;

    // on release the search starts just past the owner and excludes it
    assign arb_ptr = (state == BUSY) ? ID'(wrap_inc(int'(grant_id), REQ)) : ptr;
    assign arb_req = req & ~grant;

    for (genvar i = 0; i < REQ; i++) begin : g_mask
        assign mask[i] = ge_bit(i, int'(arb_ptr));
    end

    pri_enc #(.W(REQ), .ACT("HIGH")) u_masked (
        .vec    (arb_req & mask),
        .onehot (m_onehot),
        .idx    (m_idx),
        .valid  (m_valid)
    );

    pri_enc #(.W(REQ), .ACT("HIGH")) u_full (
        .vec    (arb_req),
        .onehot (u_onehot),
        .idx    (u_idx),
        .valid  (u_valid)
    );

    assign win     = m_valid ? m_onehot : u_onehot;
    assign win_idx = m_valid ? m_idx : u_idx;

    always_comb begin
        state_n = state;
        grant_n = grant;
        id_n    = grant_id;
        ptr_n   = ptr;
        to_n    = 1'b0;
        if (state == IDLE || release_c) begin
            grant_n = win;
            id_n    = u_valid ? win_idx : grant_id;
            state_n = u_valid ? BUSY : IDLE;
            ptr_n   = arb_ptr;
            to_n    = forced;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            grant_id <= id_n;
            ptr      <= ptr_n;
            timeout  <= to_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed stimulus with a rotation-based reference model checked every cycle
module tb_rr_arbiter;

    localparam int REQ  = 8;
    localparam int MAXH = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       done = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_hold = 0;
    int m_id = 0;
    bit m_to = 1'b0;

    always #10 clk = ~clk;

    rr_arbiter #(.REQ(REQ), .MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // first requester found walking upward from the pointer, wrapping around
    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < REQ; k++)
            if (r[(p + k) % REQ]) return (p + k) % REQ;
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [7:0] r;
        int         w;
        bit         f;
        r = req;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_id    = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            w    = pick(r, m_ptr);
            m_to = 1'b0;
            if (w >= 0) begin
                m_owner = w;
                m_id    = w;
                m_hold  = 0;
            end
        end else begin
            f    = TO_EN && (m_hold == MAXH - 1) && !done && r[m_owner];
            m_to = f;
            if (done || !r[m_owner] || f) begin
                m_ptr      = (m_owner + 1) % REQ;
                r[m_owner] = 1'b0;
                w          = pick(r, m_ptr);
                m_owner    = w;
                m_hold     = 0;
                if (w >= 0) m_id = w;
            end else begin
                m_hold++;
            end
        end
        #2;
        if (!reset) begin
            chk("model_grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
            chk("model_valid", grant_valid, m_owner >= 0);
            chk("model_id", grant_id, m_id);
            chk("model_timeout", timeout, m_to);
        end
    end

    task automatic step(input logic [7:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        #3;
    endtask

    initial begin
        req   = 8'hFF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", grant_valid, 1'b0);
        chk("rst_id", grant_id, 3'd0);
        chk("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #3;
        chk("first_grant", grant, 8'h01);

        for (int i = 0; i < 8; i++) begin
            chk("rot_id", grant_id, i);
            step(8'hFF, 1'b0);
            step(8'hFF, 1'b0);
            chk("rot_hold", grant_id, i);
            step(8'hFF, 1'b1);
            chk("rot_next", grant_id, (i + 1) % 8);
            chk("rot_valid", grant_valid, 1'b1);
        end

        step(8'h00, 1'b0);
        chk("drop_idle", grant, 8'h00);
        step(8'h10, 1'b0);
        chk("grant4", grant_id, 3'd4);
        step(8'h11, 1'b1);
        chk("wrap_id", grant_id, 3'd0);
        chk("wrap_grant", grant, 8'h01);
        step(8'h10, 1'b0);
        chk("drop_to4", grant_id, 3'd4);

        step(8'h04, 1'b0);
        chk("sole_id", grant_id, 3'd2);
        step(8'h04, 1'b1);
        chk("bubble_grant", grant, 8'h00);
        chk("bubble_valid", grant_valid, 1'b0);
        chk("bubble_id", grant_id, 3'd2);
        step(8'h04, 1'b0);
        chk("regrant", grant, 8'h04);

        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("idle_done", grant, 8'h00);
        step(8'h08, 1'b0);
        chk("grant8", grant, 8'h08);

        #3;
        reset = 1'b1;
        #1;
        chk("async_grant", grant, 8'h00);
        chk("async_valid", grant_valid, 1'b0);
        chk("async_id", grant_id, 3'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        @(posedge clk);
        #3;
        chk("ptr_reset", grant, 8'h01);

        @(negedge clk);
        reset = 1'b1;
        req   = 8'h03;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #3;
        chk("hold_id0", grant_id, 3'd0);
        for (int k = 0; k < 3; k++) begin
            step(8'h03, 1'b0);
            chk("hold_id", grant_id, 3'd0);
            chk("hold_to", timeout, 1'b0);
        end
        step(8'h03, 1'b0);
        chk("to_id", grant_id, TO_EN ? 3'd1 : 3'd0);
        chk("to_pulse", timeout, TO_EN);
        step(8'h03, 1'b0);
        chk("to_clear", timeout, 1'b0);

        repeat (2) @(posedge clk);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
